// File: rtl/minirisc_pkg.sv
// rtl/minirisc_pkg.sv - shared miniRISC constants, sequencer state enum and opcode helpers
// Purpose: single home for opcode literals used by the branch decision logic,
//          the control unit and the PC sequencer.
// Contents: OP_* opcode constants, INSTR_BYTES, pc_state_e, is_branch_op().
package minirisc_pkg;

  localparam logic [5:0] OP_BLTZ = 6'b000111;
  localparam logic [5:0] OP_BZ   = 6'b001000;
  localparam logic [5:0] OP_BNZ  = 6'b001001;
  localparam logic [5:0] OP_BR   = 6'b001010;
  localparam logic [5:0] OP_B    = 6'b001011;
  localparam logic [5:0] OP_BL   = 6'b001100;
  localparam logic [5:0] OP_BCY  = 6'b001101;
  localparam logic [5:0] OP_BNCY = 6'b001110;

  localparam int INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    RUN      = 2'd1,
    REDIRECT = 2'd2,
    HALTED   = 2'd3
  } pc_state_e;

  // True for every opcode that may redirect the PC when taken.
  function automatic logic is_branch_op(input logic [5:0] op);
    logic hit;
    case (op)
      OP_BLTZ, OP_BZ, OP_BNZ, OP_BR, OP_B, OP_BL, OP_BCY, OP_BNCY: hit = 1'b1;
      default:                                                     hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/pc_target_calc.sv
// rtl/pc_target_calc.sv - combinational next-PC candidates for the sequencer
// Purpose: produce the fall-through address and the branch target.
// Ports:
//   pc            in   current PC
//   opcode        in   opcode of the committing instruction
//   branch_offset in   signed word offset relative to pc
//   reg_target    in   rs value used by br
//   seq_pc        out  pc + 4
//   redirect_pc   out  branch target (br: aligned reg_target, else pc + offset*4)
module pc_target_calc
  import minirisc_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [5:0]        opcode,
  input  logic [ADDR_W-1:0] branch_offset,
  input  logic [ADDR_W-1:0] reg_target,
  output logic [ADDR_W-1:0] seq_pc,
  output logic [ADDR_W-1:0] redirect_pc
);

  // All sums are truncated to ADDR_W, so wrap-around is modulo 2^ADDR_W.
  always_comb begin
    seq_pc = pc + ADDR_W'(INSTR_BYTES);
    if (opcode == OP_BR) begin
      // Register-indirect targets are forced word aligned.
      redirect_pc = reg_target & ~ADDR_W'(3);
    end else begin
      redirect_pc = pc + (branch_offset << 2);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - miniRISC program-counter sequencer with link write and fetch tracking
// Purpose: register the next PC on each commit, insert a one-cycle fetch bubble
//          after taken branches, write the bl return address and halt the core.
// Ports:
//   clk, rst      in   clock, asynchronous active-high reset
//   pc_en         in   commit strobe for the instruction at pc
//   halt          in   committing instruction is a halt (qualified by pc_en)
//   opcode        in   opcode of the committing instruction
//   branch_taken  in   branch decision
//   branch_offset in   signed word offset relative to pc
//   reg_target    in   rs value for br
//   pc            out  current PC / instruction memory address
//   fetch_valid   out  instruction memory output matches pc
//   link_we       out  one-cycle r31 write strobe
//   link_addr     out  bl return address
//   halted        out  core halted
module pc_sequencer
  import minirisc_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_en,
  input  logic              halt,
  input  logic [5:0]        opcode,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_offset,
  input  logic [ADDR_W-1:0] reg_target,
  output logic [ADDR_W-1:0] pc,
  output logic              fetch_valid,
  output logic              link_we,
  output logic [ADDR_W-1:0] link_addr,
  output logic              halted
);

  pc_state_e         state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              fetch_valid_q, fetch_valid_d;
  logic              link_we_q, link_we_d;
  logic [ADDR_W-1:0] link_addr_q, link_addr_d;
  logic              halted_q, halted_d;

  logic [ADDR_W-1:0] seq_pc;
  logic [ADDR_W-1:0] redirect_pc;

  pc_target_calc #(.ADDR_W(ADDR_W)) u_target (
    .pc            (pc_q),
    .opcode        (opcode),
    .branch_offset (branch_offset),
    .reg_target    (reg_target),
    .seq_pc        (seq_pc),
    .redirect_pc   (redirect_pc)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    link_we_d   = 1'b0;  // strobe lasts only the cycle after a bl commit
    link_addr_d = link_addr_q;
    halted_d    = halted_q;
    case (state_q)
      BOOT:     state_d = RUN;
      REDIRECT: state_d = RUN;
      RUN: begin
        if (pc_en) begin
          if (halt) begin
            // Halt wins over any simultaneous redirect; pc holds.
            state_d  = HALTED;
            halted_d = 1'b1;
          end else if (branch_taken && is_branch_op(opcode)) begin
            state_d = REDIRECT;
            pc_d    = redirect_pc;
            if (opcode == OP_BL) begin
              link_we_d   = 1'b1;
              link_addr_d = seq_pc;
            end
          end else begin
            pc_d = seq_pc;
          end
        end
      end
      default:  state_d = HALTED;  // HALTED: terminal, commits ignored
    endcase
    // Fetch is only valid once the memory has had a full cycle on a stable pc.
    fetch_valid_d = (state_d == RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      fetch_valid_q <= 1'b0;
      link_we_q     <= 1'b0;
      link_addr_q   <= '0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_valid_q <= fetch_valid_d;
      link_we_q     <= link_we_d;
      link_addr_q   <= link_addr_d;
      halted_q      <= halted_d;
    end
  end

  assign pc          = pc_q;
  assign fetch_valid = fetch_valid_q;
  assign link_we     = link_we_q;
  assign link_addr   = link_addr_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer
module tb_pc_sequencer;
  import minirisc_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pc_en = 1'b0;
  logic        halt = 1'b0;
  logic [5:0]  opcode = 6'b000000;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_offset = 32'h0;
  logic [31:0] reg_target = 32'h0;
  logic [31:0] pc;
  logic        fetch_valid;
  logic        link_we;
  logic [31:0] link_addr;
  logic        halted;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_sequencer #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
    .clk           (clk),
    .rst           (rst),
    .pc_en         (pc_en),
    .halt          (halt),
    .opcode        (opcode),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .reg_target    (reg_target),
    .pc            (pc),
    .fetch_valid   (fetch_valid),
    .link_we       (link_we),
    .link_addr     (link_addr),
    .halted        (halted)
  );

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pc_en = 1'b0; halt = 1'b0; opcode = 6'b000000;
    branch_taken = 1'b0; branch_offset = 32'h0; reg_target = 32'h0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    step(); step();
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp %h", pc, 32'h0); end
    checks++; if ({fetch_valid, link_we, halted} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {fetch_valid, link_we, halted}); end
    checks++; if (link_addr !== 32'h0) begin errors++; $display("FAIL reset_link_addr got %h exp %h", link_addr, 32'h0); end
    rst = 1'b0;
    #1;
    checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL boot_fv got %b exp 0", fetch_valid); end
    step();
    checks++; if (fetch_valid !== 1'b1 || pc !== 32'h0) begin errors++; $display("FAIL run_entry got fv=%b pc=%h exp fv=1 pc=0", fetch_valid, pc); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc [3];
    exp_pc[0] = 32'h4; exp_pc[1] = 32'h8; exp_pc[2] = 32'hC;
    pc_en = 1'b1; opcode = 6'b000000;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (pc !== exp_pc[i] || fetch_valid !== 1'b1) begin errors++; $display("FAIL seq_%0d got pc=%h fv=%b exp pc=%h fv=1", i, pc, fetch_valid, exp_pc[i]); end
    end
    step(); // 0x10
    pc_en = 1'b0;
    checks++; if (pc !== 32'h10) begin errors++; $display("FAIL seq_3 got %h exp %h", pc, 32'h10); end
  endtask

  task automatic test_branch_back();
    pc_en = 1'b1; opcode = OP_B; branch_taken = 1'b1; branch_offset = 32'hFFFF_FFFE;
    step();
    checks++; if (pc !== 32'h08 || fetch_valid !== 1'b0) begin errors++; $display("FAIL b_back got pc=%h fv=%b exp pc=00000008 fv=0", pc, fetch_valid); end
    // Commit during the bubble must be ignored.
    opcode = 6'b000000; branch_taken = 1'b0; branch_offset = 32'h0;
    step();
    checks++; if (pc !== 32'h08 || fetch_valid !== 1'b1) begin errors++; $display("FAIL bubble_ignore got pc=%h fv=%b exp pc=00000008 fv=1", pc, fetch_valid); end
    // Forward b by 6 words to reach 0x20.
    opcode = OP_B; branch_taken = 1'b1; branch_offset = 32'd6;
    step();
    pc_en = 1'b0;
    step();
    checks++; if (pc !== 32'h20 || fetch_valid !== 1'b1) begin errors++; $display("FAIL b_fwd got pc=%h fv=%b exp pc=00000020 fv=1", pc, fetch_valid); end
  endtask

  task automatic test_bl();
    pc_en = 1'b1; opcode = OP_BL; branch_taken = 1'b1; branch_offset = 32'd4;
    step();
    idle_inputs();
    checks++; if (pc !== 32'h30 || fetch_valid !== 1'b0) begin errors++; $display("FAIL bl_pc got pc=%h fv=%b exp pc=00000030 fv=0", pc, fetch_valid); end
    checks++; if (link_we !== 1'b1 || link_addr !== 32'h24) begin errors++; $display("FAIL bl_link got we=%b addr=%h exp we=1 addr=00000024", link_we, link_addr); end
    step();
    checks++; if (link_we !== 1'b0 || fetch_valid !== 1'b1) begin errors++; $display("FAIL bl_pulse got we=%b fv=%b exp we=0 fv=1", link_we, fetch_valid); end
  endtask

  task automatic test_br_and_untaken();
    pc_en = 1'b1; opcode = OP_BR; branch_taken = 1'b1; reg_target = 32'h103;
    step();
    pc_en = 1'b0;
    checks++; if (pc !== 32'h100 || fetch_valid !== 1'b0) begin errors++; $display("FAIL br got pc=%h fv=%b exp pc=00000100 fv=0", pc, fetch_valid); end
    step();
    pc_en = 1'b1; opcode = OP_BZ; branch_taken = 1'b0; reg_target = 32'h0; branch_offset = 32'd8;
    step();
    checks++; if (pc !== 32'h104 || fetch_valid !== 1'b1) begin errors++; $display("FAIL bz_untaken got pc=%h fv=%b exp pc=00000104 fv=1", pc, fetch_valid); end
    opcode = 6'b000001; branch_taken = 1'b1;
    step();
    pc_en = 1'b0;
    checks++; if (pc !== 32'h108 || fetch_valid !== 1'b1) begin errors++; $display("FAIL nonbranch_taken got pc=%h fv=%b exp pc=00000108 fv=1", pc, fetch_valid); end
  endtask

  task automatic test_wrap_and_halt();
    pc_en = 1'b1; opcode = OP_BR; branch_taken = 1'b1; reg_target = 32'hFFFF_FFFE;
    step();
    pc_en = 1'b0;
    step();
    checks++; if (pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL br_top got %h exp %h", pc, 32'hFFFF_FFFC); end
    pc_en = 1'b1; opcode = 6'b000000; branch_taken = 1'b0;
    step();
    checks++; if (pc !== 32'h0 || fetch_valid !== 1'b1) begin errors++; $display("FAIL wrap got pc=%h fv=%b exp pc=00000000 fv=1", pc, fetch_valid); end
    halt = 1'b1; opcode = OP_B; branch_taken = 1'b1; branch_offset = 32'd5;
    step();
    checks++; if (halted !== 1'b1 || pc !== 32'h0 || fetch_valid !== 1'b0) begin errors++; $display("FAIL halt got h=%b pc=%h fv=%b exp h=1 pc=00000000 fv=0", halted, pc, fetch_valid); end
    halt = 1'b0; opcode = 6'b000000; branch_taken = 1'b0;
    step(); step();
    checks++; if (halted !== 1'b1 || pc !== 32'h0 || fetch_valid !== 1'b0) begin errors++; $display("FAIL halt_hold got h=%b pc=%h fv=%b exp h=1 pc=00000000 fv=0", halted, pc, fetch_valid); end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    rst = 1'b1; step(); rst = 1'b0;
    step(); // BOOT -> RUN
    pc_en = 1'b1; opcode = OP_BL; branch_taken = 1'b1; branch_offset = 32'd3;
    step();
    idle_inputs();
    checks++; if (link_we !== 1'b1 || pc !== 32'hC || link_addr !== 32'h4) begin errors++; $display("FAIL pre_rst got we=%b pc=%h la=%h exp we=1 pc=0000000c la=00000004", link_we, pc, link_addr); end
    #3 rst = 1'b1;
    #1;
    checks++; if (pc !== 32'h0 || link_addr !== 32'h0) begin errors++; $display("FAIL async_rst_vals got pc=%h la=%h exp 0 0", pc, link_addr); end
    checks++; if ({fetch_valid, link_we, halted} !== 3'b000) begin errors++; $display("FAIL async_rst_flags got %b exp 000", {fetch_valid, link_we, halted}); end
    step();
    rst = 1'b0;
    step(); step();
    checks++; if (link_we !== 1'b0 || fetch_valid !== 1'b1 || pc !== 32'h0) begin errors++; $display("FAIL post_rst got we=%b fv=%b pc=%h exp we=0 fv=1 pc=0", link_we, fetch_valid, pc); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch_back();
    test_bl();
    test_br_and_untaken();
    test_wrap_and_halt();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
